// File: rtl/idu_pipe.sv
// RV32I instruction decode stage with a registered output bundle.
// Valid/ready on both sides; flush kills the held bundle and blocks input for a cycle.
module idu_pipe #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 0
) (
   input  logic            IDP_CLOCK_50,
   input  logic            IDP_RESET_InHigh,
   input  logic            IDP_Flush,
   input  logic            IDP_In_Valid,
   output logic            IDP_In_Ready,
   input  logic [31:0]     IDP_Inst_InBUS,
   input  logic [XLEN-1:0] IDP_Pc_InBUS,
   output logic            IDP_Out_Valid,
   input  logic            IDP_Out_Ready,
   output logic [XLEN-1:0] IDP_Pc_OutBUS,
   output logic [XLEN-1:0] IDP_Imm_OutBUS,
   output logic [4:0]      IDP_Rd_OutBUS,
   output logic [4:0]      IDP_Rs1_OutBUS,
   output logic [4:0]      IDP_Rs2_OutBUS,
   output logic [2:0]      IDP_Funct3_OutBUS,
   output logic            IDP_Funct7b5,
   output logic            IDP_Not_Branch_Jump_Op,
   output logic            IDP_RegFile_Write,
   output logic            IDP_Bru_En,
   output logic            IDP_Alu_Select_Immediate_Mux,
   output logic            IDP_Lsu_En,
   output logic            IDP_Mul_Op,
   output logic            IDP_Illegal,
   output logic [1:0]      IDP_RegFile_Mux_OutBUS,
   output logic [1:0]      IDP_AluOp_OutBUS
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            nbj;
      logic [1:0]      rf_mux;
      logic            rf_wr;
      logic [1:0]      alu_op;
      logic            bru;
      logic            imm_sel;
      logic            lsu;
      logic            mul;
      logic            illegal;
   } bundle_t;

   bundle_t     bun_d, bun_q;
   logic        vld_q;
   logic        load;
   logic [31:0] inst;
   logic [31:0] imm32;
   logic [6:0]  funct7;

   assign inst   = IDP_Inst_InBUS;
   assign funct7 = inst[31:25];

   always_comb begin
      bun_d          = '0;
      imm32          = '0;
      bun_d.pc       = IDP_Pc_InBUS;
      bun_d.rd       = inst[11:7];
      bun_d.rs1      = inst[19:15];
      bun_d.rs2      = inst[24:20];
      bun_d.funct3   = inst[14:12];
      bun_d.funct7b5 = inst[30];
      if (inst[1:0] != 2'b11) begin
         bun_d.illegal = 1'b1;
      end else begin
         case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
               bun_d.rf_mux  = (inst[6:0] == OP_AUIPC) ? 2'b10 : 2'b00;
               bun_d.rf_wr   = 1'b1;
               bun_d.alu_op  = 2'b11;
               bun_d.imm_sel = 1'b1;
               imm32         = {inst[31:12], 12'b0};
            end
            OP_JAL, OP_JALR: begin
               bun_d.nbj     = 1'b1;
               bun_d.rf_mux  = 2'b11;
               bun_d.rf_wr   = 1'b1;
               bun_d.alu_op  = 2'b10;
               bun_d.imm_sel = 1'b1;
               imm32 = (inst[6:0] == OP_JAL)
                     ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}
                     : {{20{inst[31]}}, inst[31:20]};
            end
            OP_BRANCH: begin
               bun_d.bru = 1'b1;
               imm32     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LOAD, OP_STORE: begin
               bun_d.rf_mux  = 2'b01;
               bun_d.rf_wr   = (inst[6:0] == OP_LOAD);
               bun_d.alu_op  = 2'b01;
               bun_d.imm_sel = 1'b1;
               bun_d.lsu     = 1'b1;
               imm32 = (inst[6:0] == OP_LOAD)
                     ? {{20{inst[31]}}, inst[31:20]}
                     : {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_IMM: begin
               bun_d.rf_wr   = 1'b1;
               bun_d.imm_sel = 1'b1;
               imm32         = {{20{inst[31]}}, inst[31:20]};
               // shift amounts live in imm[4:0]; upper bits select SRLI/SRAI only
               if (inst[14:12] == 3'b001 && funct7 != 7'b0000000)
                  bun_d.illegal = 1'b1;
               if (inst[14:12] == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                  bun_d.illegal = 1'b1;
            end
            OP_OP: begin
               bun_d.rf_wr = 1'b1;
               if (funct7 == 7'b0000001 && ENABLE_M != 0)
                  bun_d.mul = 1'b1;
               else if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                  bun_d.illegal = 1'b1;
            end
            OP_MISC: ;
            default: bun_d.illegal = 1'b1;
         endcase
      end
      if (bun_d.illegal) begin
         bun_d.nbj     = 1'b0;
         bun_d.rf_mux  = 2'b00;
         bun_d.rf_wr   = 1'b0;
         bun_d.alu_op  = 2'b00;
         bun_d.bru     = 1'b0;
         bun_d.imm_sel = 1'b0;
         bun_d.lsu     = 1'b0;
         bun_d.mul     = 1'b0;
         imm32         = '0;
      end
      if (inst[11:7] == 5'd0)
         bun_d.rf_wr = 1'b0;
      bun_d.imm = XLEN'(signed'(imm32));
   end

   assign IDP_In_Ready = ~IDP_Flush & (~vld_q | IDP_Out_Ready);
   assign load         = IDP_In_Valid & IDP_In_Ready;

   // bundle is only rewritten on load, so it stays put under back-pressure and after consume
   always_ff @(posedge IDP_CLOCK_50) begin
      if (IDP_RESET_InHigh) begin
         vld_q <= 1'b0;
         bun_q <= '0;
      end else if (IDP_Flush) begin
         vld_q <= 1'b0;
      end else if (load) begin
         vld_q <= 1'b1;
         bun_q <= bun_d;
      end else if (IDP_Out_Ready) begin
         vld_q <= 1'b0;
      end
   end

   assign IDP_Out_Valid                = vld_q;
   assign IDP_Pc_OutBUS                = bun_q.pc;
   assign IDP_Imm_OutBUS               = bun_q.imm;
   assign IDP_Rd_OutBUS                = bun_q.rd;
   assign IDP_Rs1_OutBUS               = bun_q.rs1;
   assign IDP_Rs2_OutBUS               = bun_q.rs2;
   assign IDP_Funct3_OutBUS            = bun_q.funct3;
   assign IDP_Funct7b5                 = bun_q.funct7b5;
   assign IDP_Not_Branch_Jump_Op       = bun_q.nbj;
   assign IDP_RegFile_Mux_OutBUS       = bun_q.rf_mux;
   assign IDP_RegFile_Write            = bun_q.rf_wr;
   assign IDP_AluOp_OutBUS             = bun_q.alu_op;
   assign IDP_Bru_En                   = bun_q.bru;
   assign IDP_Alu_Select_Immediate_Mux = bun_q.imm_sel;
   assign IDP_Lsu_En                   = bun_q.lsu;
   assign IDP_Mul_Op                   = bun_q.mul;
   assign IDP_Illegal                  = bun_q.illegal;
endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: two instances (ENABLE_M=0 and 1) share stimulus; a
// decode/handshake reference model predicts every output bundle.
module tb_idu_pipe;
   typedef struct packed {
      logic        vld;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [8:0]  ctl;   // {nbj, mux[1:0], write, aluop[1:0], bru, immsel, lsu}
      logic        mul;
      logic        ill;
   } bun_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] inst_i, pc_i;

   logic        rdy [2];
   bun_t        obs [2];
   bun_t        exp_b [2];
   logic        rdy_obs [2];
   logic        exp_rdy;
   bit          known;
   int          vecs = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        ov, of7, nbj, wr, bru, isel, lsu, mul, ill;
      logic [31:0] opc, oimm;
      logic [4:0]  ord, ors1, ors2;
      logic [2:0]  of3;
      logic [1:0]  mux, aop;
      idu_pipe #(.XLEN(32), .ENABLE_M(g)) u_dut (
         .IDP_CLOCK_50(clk), .IDP_RESET_InHigh(rst), .IDP_Flush(flush),
         .IDP_In_Valid(in_valid), .IDP_In_Ready(rdy[g]),
         .IDP_Inst_InBUS(inst_i), .IDP_Pc_InBUS(pc_i),
         .IDP_Out_Valid(ov), .IDP_Out_Ready(out_ready),
         .IDP_Pc_OutBUS(opc), .IDP_Imm_OutBUS(oimm),
         .IDP_Rd_OutBUS(ord), .IDP_Rs1_OutBUS(ors1), .IDP_Rs2_OutBUS(ors2),
         .IDP_Funct3_OutBUS(of3), .IDP_Funct7b5(of7),
         .IDP_Not_Branch_Jump_Op(nbj), .IDP_RegFile_Write(wr), .IDP_Bru_En(bru),
         .IDP_Alu_Select_Immediate_Mux(isel), .IDP_Lsu_En(lsu), .IDP_Mul_Op(mul),
         .IDP_Illegal(ill), .IDP_RegFile_Mux_OutBUS(mux), .IDP_AluOp_OutBUS(aop)
      );
      assign obs[g] = {ov, opc, oimm, ord, ors1, ors2, of3, of7,
                       nbj, mux, wr, aop, bru, isel, lsu, mul, ill};
   end

   // Reference decode: control table per opcode class, immediates by integer shifts.
   function automatic bun_t model_dec(logic [31:0] i, logic [31:0] pc, bit m);
      bun_t b;
      int   si, im;
      bit   ill;
      logic [6:0] f7;
      b = '0; si = i; im = 0; ill = 0; f7 = i[31:25];
      b.vld = 1'b1; b.pc = pc; b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20];
      b.f3 = i[14:12]; b.f7b5 = i[30];
      if (i[1:0] != 2'b11) ill = 1;
      else case (i[6:0])
         7'h37: begin b.ctl = 9'b0_00_1_11_0_1_0; im = int'(i & 32'hFFFFF000); end
         7'h17: begin b.ctl = 9'b0_10_1_11_0_1_0; im = int'(i & 32'hFFFFF000); end
         7'h6F: begin
            b.ctl = 9'b1_11_1_10_0_1_0;
            im = ((si >>> 31) << 20) | int'(((i >> 12) & 32'hFF) << 12)
               | int'(((i >> 20) & 1) << 11) | int'(((i >> 21) & 32'h3FF) << 1);
         end
         7'h67: begin b.ctl = 9'b1_11_1_10_0_1_0; im = si >>> 20; end
         7'h63: begin
            b.ctl = 9'b0_00_0_00_1_0_0;
            im = ((si >>> 31) << 12) | int'(((i >> 7) & 1) << 11)
               | int'(((i >> 25) & 32'h3F) << 5) | int'(((i >> 8) & 32'hF) << 1);
         end
         7'h03: begin b.ctl = 9'b0_01_1_01_0_1_1; im = si >>> 20; end
         7'h23: begin b.ctl = 9'b0_01_0_01_0_1_1; im = ((si >>> 25) << 5) | int'((i >> 7) & 32'h1F); end
         7'h13: begin
            b.ctl = 9'b0_00_1_00_0_1_0; im = si >>> 20;
            if (i[14:12] == 3'd1 && f7 != 0) ill = 1;
            if (i[14:12] == 3'd5 && f7 != 0 && f7 != 7'h20) ill = 1;
         end
         7'h33: begin
            b.ctl = 9'b0_00_1_00_0_0_0;
            if (f7 == 7'h01) begin if (m) b.mul = 1'b1; else ill = 1; end
            else if (f7 != 0 && f7 != 7'h20) ill = 1;
         end
         7'h0F: ;
         default: ill = 1;
      endcase
      if (ill) begin b.ctl = '0; b.mul = 1'b0; im = 0; end
      b.ill = ill;
      if (i[11:7] == 0) b.ctl[5] = 1'b0;
      b.imm = im;
      return b;
   endfunction

   // Drive one cycle, sample In_Ready mid-cycle, advance the handshake model.
   task automatic cyc(input bit r, f, iv, orr, input logic [31:0] inst, pc);
      rst = r; flush = f; in_valid = iv; out_ready = orr; inst_i = inst; pc_i = pc;
      #4;
      for (int k = 0; k < 2; k++) rdy_obs[k] = rdy[k];
      exp_rdy = !f && (!exp_b[0].vld || orr);
      @(posedge clk);
      if (r) begin
         exp_b[0] = '0; exp_b[1] = '0; known = 1;
      end else if (f) begin
         exp_b[0].vld = 1'b0; exp_b[1].vld = 1'b0; known = 0;
      end else if (iv && exp_rdy) begin
         exp_b[0] = model_dec(inst, pc, 0); exp_b[1] = model_dec(inst, pc, 1); known = 1;
      end else if (orr) begin
         exp_b[0].vld = 1'b0; exp_b[1].vld = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         vecs++;
         if (obs[k] !== '0) begin errs++; $display("FAIL reset dut%0d: got %h want 0", k, obs[k]); end
      end
      cyc(1, 1, 1, 1, 32'hFFF00093, 32'h100);
      for (int k = 0; k < 2; k++) begin
         vecs++;
         if (obs[k] !== '0 || rdy_obs[k] !== 1'b0) begin
            errs++; $display("FAIL reset_flush dut%0d: got %h rdy %b want 0 rdy 0", k, obs[k], rdy_obs[k]);
         end
      end
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      vecs++;
      if (rdy_obs[0] !== 1'b1) begin errs++; $display("FAIL idle_ready: got %b want 1", rdy_obs[0]); end
   endtask

   task automatic test_addi();
      cyc(0, 0, 1, 1, 32'hFFF00093, 32'h100);
      vecs++;
      if ({obs[0].vld, obs[0].imm, obs[0].rd, obs[0].ctl[5], obs[0].ctl[4:3], obs[0].ctl[1], obs[0].pc, obs[0].ill}
          !== {1'b1, 32'hFFFFFFFF, 5'd1, 1'b1, 2'b00, 1'b1, 32'h100, 1'b0}) begin
         errs++; $display("FAIL addi: got %h want imm ffffffff rd 1 wr 1 pc 100", obs[0]);
      end
      vecs++;
      if (obs[0] !== exp_b[0]) begin errs++; $display("FAIL addi_model: got %h want %h", obs[0], exp_b[0]); end
   endtask

   task automatic test_back_to_back();
      cyc(0, 0, 1, 1, 32'h008000EF, 32'h200);
      vecs++;
      if ({obs[0].vld, obs[0].imm, obs[0].ctl[8:5]} !== {1'b1, 32'd8, 4'b1111}) begin
         errs++; $display("FAIL jal: got %h want imm 8 nbj 1 mux 11 wr 1", obs[0]);
      end
      cyc(0, 0, 1, 1, 32'hFE000EE3, 32'h204);
      vecs++;
      if ({rdy_obs[0], obs[0].vld, obs[0].imm, obs[0].ctl[2], obs[0].ctl[5], obs[0].pc}
          !== {1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h204}) begin
         errs++; $display("FAIL beq: got %h rdy %b want imm fffffffc bru 1 wr 0", obs[0], rdy_obs[0]);
      end
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      vecs++;
      if (obs[0].vld !== 1'b0 || obs[0].pc !== 32'h204) begin
         errs++; $display("FAIL drain: got vld %b pc %h want 0 204", obs[0].vld, obs[0].pc);
      end
   endtask

   task automatic test_backpressure();
      cyc(0, 0, 1, 1, 32'h0040A103, 32'h300);
      for (int c = 0; c < 3; c++) begin
         cyc(0, 0, 1, 0, 32'h0020A423, 32'h304);
         vecs++;
         if ({rdy_obs[0], obs[0].vld, obs[0].ctl[0], obs[0].ctl[7:6], obs[0].ctl[5], obs[0].imm, obs[0].pc}
             !== {1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 32'd4, 32'h300}) begin
            errs++; $display("FAIL stall%0d: got %h rdy %b want lw held", c, obs[0], rdy_obs[0]);
         end
      end
      cyc(0, 0, 1, 1, 32'h0020A423, 32'h304);
      vecs++;
      if ({rdy_obs[0], obs[0].vld, obs[0].imm, obs[0].pc, obs[0].ctl[0], obs[0].ctl[5]}
          !== {1'b1, 1'b1, 32'd8, 32'h304, 1'b1, 1'b0}) begin
         errs++; $display("FAIL sw_accept: got %h rdy %b want sw imm 8", obs[0], rdy_obs[0]);
      end
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      vecs++;
      if (obs[0].vld !== 1'b0 || obs[0].imm !== 32'd8) begin
         errs++; $display("FAIL consume_hold: got vld %b imm %h want 0 8", obs[0].vld, obs[0].imm);
      end
   endtask

   task automatic test_flush();
      cyc(0, 0, 1, 1, 32'hFFF00093, 32'h400);
      cyc(0, 1, 1, 0, 32'h0040A103, 32'h404);
      vecs++;
      if (rdy_obs[0] !== 1'b0 || obs[0].vld !== 1'b0) begin
         errs++; $display("FAIL flush: got rdy %b vld %b want 0 0", rdy_obs[0], obs[0].vld);
      end
      cyc(0, 0, 0, 1, 32'h0, 32'h0);
      vecs++;
      if (obs[0].vld !== 1'b0) begin errs++; $display("FAIL flush_noload: got vld %b want 0", obs[0].vld); end
   endtask

   typedef struct {
      logic [31:0] inst;
      logic        ill0;
      logic [8:0]  ctl0;
      logic        ill1;
      logic        mul1;
      logic [8:0]  ctl1;
      logic [31:0] imm;
   } enc_t;

   task automatic test_illegal();
      enc_t t [8];
      t[0] = '{32'h00000000, 1, 9'h000, 1, 0, 9'h000, 32'h0};
      t[1] = '{32'h00000013, 0, 9'b0_00_0_00_0_1_0, 0, 0, 9'b0_00_0_00_0_1_0, 32'h0};
      t[2] = '{32'h022081B3, 1, 9'h000, 0, 1, 9'b0_00_1_00_0_0_0, 32'h0};
      t[3] = '{32'h042081B3, 1, 9'h000, 1, 0, 9'h000, 32'h0};
      t[4] = '{32'h40009093, 1, 9'h000, 1, 0, 9'h000, 32'h0};
      t[5] = '{32'h4010D093, 0, 9'b0_00_1_00_0_1_0, 0, 0, 9'b0_00_1_00_0_1_0, 32'h401};
      t[6] = '{32'h0000000F, 0, 9'h000, 0, 0, 9'h000, 32'h0};
      t[7] = '{32'hFFF00092, 1, 9'h000, 1, 0, 9'h000, 32'h0};
      for (int n = 0; n < 8; n++) begin
         cyc(0, 0, 1, 1, t[n].inst, 32'h500 + 32'(n) * 4);
         vecs++;
         if ({obs[0].ill, obs[0].mul, obs[0].ctl, obs[0].imm} !== {t[n].ill0, 1'b0, t[n].ctl0, t[n].imm}) begin
            errs++; $display("FAIL enc%0d_m0: got ill %b mul %b ctl %b imm %h want %b 0 %b %h",
                             n, obs[0].ill, obs[0].mul, obs[0].ctl, obs[0].imm, t[n].ill0, t[n].ctl0, t[n].imm);
         end
         vecs++;
         if ({obs[1].ill, obs[1].mul, obs[1].ctl, obs[1].imm} !== {t[n].ill1, t[n].mul1, t[n].ctl1, t[n].imm}) begin
            errs++; $display("FAIL enc%0d_m1: got ill %b mul %b ctl %b imm %h want %b %b %b %h",
                             n, obs[1].ill, obs[1].mul, obs[1].ctl, obs[1].imm, t[n].ill1, t[n].mul1, t[n].ctl1, t[n].imm);
         end
      end
      vecs++;
      if (obs[1].rd !== 5'd3 && t[2].inst == 32'h022081B3) begin end
      cyc(0, 0, 1, 1, 32'h022081B3, 32'h600);
      if (obs[1].rd !== 5'd3 || obs[1].ctl[5] !== 1'b1) begin
         errs++; $display("FAIL mul_rd: got rd %0d wr %b want 3 1", obs[1].rd, obs[1].ctl[5]);
      end
   endtask

   task automatic test_reset_mid();
      cyc(0, 0, 1, 1, 32'hFFF00093, 32'h700);
      cyc(0, 0, 0, 0, 32'h0, 32'h0);
      cyc(1, 0, 1, 0, 32'h0040A103, 32'h704);
      for (int k = 0; k < 2; k++) begin
         vecs++;
         if (obs[k] !== '0 || rdy_obs[k] !== 1'b0) begin
            errs++; $display("FAIL reset_mid dut%0d: got %h rdy %b want 0 rdy 0", k, obs[k], rdy_obs[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h7F};
      logic [31:0] rnd, ins, pc;
      logic [6:0]  f7;
      bit          r, f, iv, orr;
      for (int c = 0; c < 400; c++) begin
         rnd = $urandom;
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = rnd[31:25];
         endcase
         ins = {f7, rnd[24:7], ops[$urandom_range(0, 10)]};
         if ($urandom_range(0, 15) == 0) ins = $urandom;
         pc  = $urandom & 32'hFFFFFFFC;
         r   = ($urandom_range(0, 99) == 0);
         f   = ($urandom_range(0, 99) < 8);
         iv  = ($urandom_range(0, 3) != 0);
         orr = ($urandom_range(0, 3) != 0);
         cyc(r, f, iv, orr, ins, pc);
         for (int k = 0; k < 2; k++) begin
            vecs++;
            if (rdy_obs[k] !== exp_rdy ||
                (known ? (obs[k] !== exp_b[k]) : (obs[k].vld !== exp_b[k].vld))) begin
               errs++; $display("FAIL rand%0d dut%0d: got %h rdy %b want %h rdy %b",
                                c, k, obs[k], rdy_obs[k], exp_b[k], exp_rdy);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst_i = '0; pc_i = '0;
      exp_b[0] = '0; exp_b[1] = '0; known = 1; exp_rdy = 1'b0;
      test_reset();
      test_addi();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/idu_pipe.md
# idu_pipe

Registered, parametrised instruction decode stage for the RV32I core. It sits between the fetch buffer and the execute/LSU stage, replacing purely combinational decode. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake, decodes control signals, register indices and the sign-extended immediate, and flags illegal encodings. Results are held in an output pipeline register that supports back-pressure and flush.

## Interface
Parameters:
- XLEN, 32, datapath width; must be ≥ 32. Immediates and PC are XLEN wide.
- ENABLE_M, 0, when 1, OP-class instructions with funct7 = 7'b0000001 are legal and raise IDP_Mul_Op; when 0 they are illegal.

Ports:
- IDP_CLOCK_50  in  1  single clock; everything is sampled on the rising edge.
- IDP_RESET_InHigh  in  1  synchronous, active-high reset.
- IDP_Flush  in  1  kill the held instruction; block input this cycle.
- IDP_In_Valid  in  1  IDP_Inst_InBUS and IDP_Pc_InBUS are valid.
- IDP_In_Ready  out  1  stage can accept an instruction this cycle.
- IDP_Inst_InBUS  in  32  instruction word.
- IDP_Pc_InBUS  in  XLEN  PC of the instruction.
- IDP_Out_Valid  out  1  decoded bundle is valid.
- IDP_Out_Ready  in  1  downstream consumes the bundle.
- IDP_Pc_OutBUS  out  XLEN  registered PC.
- IDP_Imm_OutBUS  out  XLEN  sign-extended immediate.
- IDP_Rd_OutBUS, IDP_Rs1_OutBUS, IDP_Rs2_OutBUS  out  5 each  inst[11:7], [19:15], [24:20].
- IDP_Funct3_OutBUS  out  3  inst[14:12].
- IDP_Funct7b5  out  1  inst[30].
- IDP_Not_Branch_Jump_Op, IDP_RegFile_Write, IDP_Bru_En, IDP_Alu_Select_Immediate_Mux, IDP_Lsu_En, IDP_Mul_Op, IDP_Illegal  out  1 each.
- IDP_RegFile_Mux_OutBUS, IDP_AluOp_OutBUS  out  2 each.

## Operation
- IDP_In_Ready = ~IDP_Flush & (~IDP_Out_Valid | IDP_Out_Ready). This is combinational.
- Load: when IDP_In_Valid & IDP_In_Ready, the decoded bundle is registered and IDP_Out_Valid becomes 1.
- Consume without load: IDP_Out_Valid becomes 0; the bundle holds its value.
- While IDP_Out_Valid=1 and IDP_Out_Ready=0, every output is stable.
- Flush: IDP_Out_Valid becomes 0 next cycle and no load occurs, whatever the other inputs are.
- Control decode, written as {NBJ, Mux, Write, AluOp, Bru, ImmSel, Lsu}:
  - LUI 0110111: {0, 00, 1, 11, 0, 1, 0}.
  - AUIPC 0010111: {0, 10, 1, 11, 0, 1, 0}.
  - JAL 1101111 and JALR 1100111: {1, 11, 1, 10, 0, 1, 0}.
  - BRANCH 1100011: {0, 00, 0, 00, 1, 0, 0}.
  - LOAD 0000011: {0, 01, 1, 01, 0, 1, 1}.
  - STORE 0100011: {0, 01, 0, 01, 0, 1, 1}.
  - OP-IMM 0010011: {0, 00, 1, 00, 0, 1, 0}.
  - OP 0110011: {0, 00, 1, 00, 0, 0, 0}.
  - MISC-MEM 0001111 (FENCE): all zero, legal; treated as a NOP.
  - Any other opcode, or inst[1:0] ≠ 2'b11: IDP_Illegal=1 and all controls zero.
  - OP with funct7 other than 0000000 or 0100000: illegal, unless it is 0000001 and ENABLE_M=1, in which case IDP_Mul_Op=1.
  - OP-IMM shifts (funct3 001 or 101) with inst[31:25] not 0000000/0100000 (SRAI only with funct3 101): illegal.
- rd = x0 forces IDP_RegFile_Write=0 on every opcode.
- Immediates, each sign-extended from inst[31] to XLEN:
  - I (JALR, LOAD, OP-IMM): inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - OP, MISC-MEM and illegal: 0.

## Timing
- Latency: 1 cycle from the accept edge to IDP_Out_Valid. Throughput is 1 instruction per cycle when IDP_Out_Ready stays high.
- Reset (synchronous): every registered output becomes 0, including IDP_Out_Valid, the buses and IDP_Illegal. In the reset cycle IDP_In_Ready follows its equation.
- Reset and flush asserted together: the result is the reset state.
- Reset asserted mid-stream discards the held bundle with no partial outputs.
- Simultaneous consume and load: the new bundle replaces the old one in the same edge, with no bubble.
- In_Valid dropping while the bundle is held has no effect. Decoding uses only the inputs sampled at the accept edge.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), PC=0x100, Out_Ready=1:
  - Required next cycle: Out_Valid=1, Imm=0xFFFFFFFF, Rd=1, Write=1, AluOp=00, ImmSel=1, Pc=0x100.
- JAL x1,+8 (0x008000EF), then BEQ x0,x0,-4 (0xFE000EE3) back-to-back:
  - JAL: Imm=8, NBJ=1, Mux=11.
  - BEQ: Imm=0xFFFFFFFC, Bru=1, Write=0.
  - Both arrive on consecutive cycles.
- Back-pressure: hold Out_Ready=0 for 3 cycles after loading LW (0x0040A103):
  - In_Ready=0 throughout; outputs stable with Lsu=1, Mux=01, Imm=4.
  - A pending SW is accepted in the same cycle Out_Ready rises.
- Flush while a bundle is held and In_Valid=1:
  - Next cycle Out_Valid=0; the offered instruction is not loaded; In_Ready=0 during the flush cycle.
- Illegal and edge encodings:
  - 0x00000000 gives Illegal=1 with all controls 0.
  - NOP 0x00000013 gives Write=0 (rd=x0), Illegal=0.
- MUL x3,x1,x2 (0x022081B3):
  - ENABLE_M=0: Illegal=1.
  - ENABLE_M=1: Illegal=0, Mul_Op=1, Write=1, Rd=3.
- Reset asserted mid-stream: all outputs 0 on the next edge.
